// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM:SS clock path: edit-FSM state encoding,
// field widths, wrap limits, edit_field codes and the wrap-around step helpers
// used when the user nudges hours/minutes up or down.
// -----------------------------------------------------------------------------
package clock_pkg;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;

   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [1:0] EF_NONE    = 2'b00;
   localparam logic [1:0] EF_HOURS   = 2'b01;
   localparam logic [1:0] EF_MINUTES = 2'b10;

   // Wrap is an explicit compare against the field maximum, so the result
   // never depends on the natural roll-over of the bit width.
   function automatic logic [HR_W-1:0] hr_step(input logic [HR_W-1:0] value,
                                               input logic             up);
      if (up) begin
         return (value == HR_MAX) ? '0 : value + 1'b1;
      end
      return (value == '0) ? HR_MAX : value - 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] value,
                                                 input logic              up);
      if (up) begin
         return (value == MIN_MAX) ? '0 : value + 1'b1;
      end
      return (value == '0) ? MIN_MAX : value - 1'b1;
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns one raw, bouncing, asynchronous push button into a clean debounced
// level and a single-cycle press pulse on the rising edge of that level.
//
// Parameters:
//   DB_CYCLES  consecutive cycles the synchronised input must disagree with the
//              debounced level before the level follows it.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   i_btn    in   raw button, active-high, asynchronous
//   o_level  out  debounced button level
//   o_press  out  one-cycle pulse per press (releases produce nothing)
//
// Latency from a clean raw press to o_press: 2 + DB_CYCLES + 1 cycles.
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_level_d;
   logic          r_press;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;

         // Any cycle that agrees with the accepted level restarts the count,
         // so only an unbroken run of DB_CYCLES disagreements flips it.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Input side of the HH:MM:SS clock. Conditions the mode/up/down buttons and
// runs the edit FSM (RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN). COMMIT issues
// a one-cycle load strobe carrying set_hr/set_min to the time counters. The
// edit_field and blink outputs let the display flash the field being edited.
//
// Configuration macro: TIME_SET_AUTO_REPEAT_EN
//   defined   : holding up/down in SET_HR/SET_MIN steps once after 500 ms and
//               then every 100 ms while held.
//   undefined : one step per press; no hold counter exists.
//
// Parameters: CLK_HZ, DEBOUNCE_MS, BLINK_HZ.
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   btn_mode    in   raw mode button
//   btn_up      in   raw up button
//   btn_down    in   raw down button
//   cur_hr      in   live hour, 0-23
//   cur_min     in   live minute, 0-59
//   set_hr      out  edited hour
//   set_min     out  edited minute
//   load        out  one-cycle load strobe
//   set_active  out  high while not in RUN
//   edit_field  out  00 none, 01 hours, 10 minutes
//   blink       out  square wave for blanking the edited field
// -----------------------------------------------------------------------------
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int DEBOUNCE_MS = 10,
   parameter int BLINK_HZ    = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_mode,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic [HR_W-1:0]  cur_hr,
   input  logic [MIN_W-1:0] cur_min,
   output logic [HR_W-1:0]  set_hr,
   output logic [MIN_W-1:0] set_min,
   output logic             load,
   output logic             set_active,
   output logic [1:0]       edit_field,
   output logic             blink
);

   localparam int DB_CYCLES  = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   // Button index: 0 = mode, 1 = up, 2 = down.
   logic [2:0] w_btn_raw;
   logic [2:0] w_level;
   logic [2:0] w_press;

   assign w_btn_raw = {btn_down, btn_up, btn_mode};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         button_conditioner #(
            .DB_CYCLES (DB_CYCLES)
         ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .i_btn   (w_btn_raw[gi]),
            .o_level (w_level[gi]),
            .o_press (w_press[gi])
         );
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_next;
   logic [HR_W-1:0]  r_set_hr;
   logic [HR_W-1:0]  w_hr_next;
   logic [MIN_W-1:0] r_set_min;
   logic [MIN_W-1:0] w_min_next;
   logic             r_load;
   logic             r_set_active;
   logic [1:0]       r_edit_field;
   logic [1:0]       w_field_next;
   logic [BW-1:0]    r_blink_cnt;
   logic             r_blink;

   logic w_rep_up;
   logic w_rep_down;

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam int REP_FIRST = CLK_HZ / 1000 * 500;
   localparam int REP_NEXT  = CLK_HZ / 1000 * 100;
   localparam int RW        = $clog2(REP_FIRST + 1);
   localparam logic [RW-1:0] REP_FIRE   = RW'(REP_FIRST - 1);
   localparam logic [RW-1:0] REP_RELOAD = RW'(REP_FIRST - REP_NEXT);

   logic [RW-1:0] r_hold_cnt;
   logic          w_hold_ok;
   logic          w_rep_fire;

   // Exactly one of up/down held, in an edit state, and no mode press about
   // to move the FSM; anything else restarts the hold timing. Mode press is
   // used instead of the next state to keep this free of a combinational loop.
   assign w_hold_ok  = ((r_state == SET_HR) || (r_state == SET_MIN)) &&
                       (w_level[1] ^ w_level[2]) && !w_press[0];
   assign w_rep_fire = w_hold_ok && (r_hold_cnt == REP_FIRE);
   assign w_rep_up   = w_rep_fire & w_level[1];
   assign w_rep_down = w_rep_fire & w_level[2];

   // After the first fire the counter is rewound so the next fire comes
   // REP_NEXT cycles later instead of REP_FIRST.
   always_ff @(posedge clk) begin
      if (!reset_n || !w_hold_ok) begin
         r_hold_cnt <= '0;
      end else if (r_hold_cnt == REP_FIRE) begin
         r_hold_cnt <= REP_RELOAD;
      end else begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end
`else
   logic [2:0] w_unused_level;

   assign w_unused_level = w_level;
   assign w_rep_up       = 1'b0;
   assign w_rep_down     = 1'b0;
`endif

   logic w_step_up;
   logic w_step_down;
   logic w_inc;
   logic w_dec;

   // Mode beats up/down; up together with down cancels out.
   assign w_step_up   = w_press[1] | w_rep_up;
   assign w_step_down = w_press[2] | w_rep_down;
   assign w_inc       = w_step_up & ~w_step_down & ~w_press[0];
   assign w_dec       = w_step_down & ~w_step_up & ~w_press[0];

   always_comb begin
      w_state_next = r_state;
      w_hr_next    = r_set_hr;
      w_min_next   = r_set_min;
      case (r_state)
         RUN: begin
            if (w_press[0]) begin
               w_hr_next    = cur_hr;
               w_min_next   = cur_min;
               w_state_next = SET_HR;
            end
         end
         SET_HR: begin
            if (w_press[0]) begin
               w_state_next = SET_MIN;
            end else if (w_inc) begin
               w_hr_next = hr_step(r_set_hr, 1'b1);
            end else if (w_dec) begin
               w_hr_next = hr_step(r_set_hr, 1'b0);
            end
         end
         SET_MIN: begin
            if (w_press[0]) begin
               w_state_next = COMMIT;
            end else if (w_inc) begin
               w_min_next = min_step(r_set_min, 1'b1);
            end else if (w_dec) begin
               w_min_next = min_step(r_set_min, 1'b0);
            end
         end
         COMMIT: begin
            w_state_next = RUN;
         end
         default: begin
            w_state_next = RUN;
         end
      endcase
   end

   always_comb begin
      w_field_next = EF_NONE;
      if (w_state_next == SET_HR) begin
         w_field_next = EF_HOURS;
      end else if (w_state_next == SET_MIN) begin
         w_field_next = EF_MINUTES;
      end
   end

   // Outputs are decoded from the next state so the registered copies line
   // up with r_state: load is high exactly while the FSM sits in COMMIT.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= RUN;
         r_set_hr     <= '0;
         r_set_min    <= '0;
         r_load       <= 1'b0;
         r_set_active <= 1'b0;
         r_edit_field <= EF_NONE;
      end else begin
         r_state      <= w_state_next;
         r_set_hr     <= w_hr_next;
         r_set_min    <= w_min_next;
         r_load       <= (w_state_next == COMMIT);
         r_set_active <= (w_state_next != RUN);
         r_edit_field <= w_field_next;
      end
   end

   logic w_edit_entry;

   // Restarting the blink phase on field entry makes the newly selected field
   // start visibly lit for a full half period.
   assign w_edit_entry = ((w_state_next == SET_HR)  && (r_state != SET_HR)) ||
                         ((w_state_next == SET_MIN) && (r_state != SET_MIN));

   always_ff @(posedge clk) begin
      if (!reset_n || w_edit_entry) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign set_hr     = r_set_hr;
   assign set_min    = r_set_min;
   assign load       = r_load;
   assign set_active = r_set_active;
   assign edit_field = r_edit_field;
   assign blink      = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with CLK_HZ = 1000, DEBOUNCE_MS = 4
// (DB_CYCLES = 4) and BLINK_HZ = 2 (blink half period 250 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// A clean press driven at a falling edge produces the internal press pulse
// after rising edge 7 and the FSM reacts at rising edge 8.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [4:0] cur_hr;
   logic [5:0] cur_min;
   logic [4:0] set_hr;
   logic [5:0] set_min;
   logic       load;
   logic       set_active;
   logic [1:0] edit_field;
   logic       blink;

   int n_cmp     = 0;
   int n_bad     = 0;
   int load_seen = 0;

   time_set_ctrl #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .BLINK_HZ    (2)
   ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_mode   (btn_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .cur_hr     (cur_hr),
      .cur_min    (cur_min),
      .set_hr     (set_hr),
      .set_min    (set_min),
      .load       (load),
      .set_active (set_active),
      .edit_field (edit_field),
      .blink      (blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (load === 1'b1) load_seen++;
   end

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the selected raw buttons long enough to register one press, then
   // release and let the debounced levels settle back to 0.
   task automatic press(input logic m, input logic u, input logic d);
      btn_mode = m;
      btn_up   = u;
      btn_down = d;
      wait_cyc(8);
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      wait_cyc(8);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n  = 1'b0;
      btn_mode = 1'b1;
      btn_up   = 1'b1;
      btn_down = 1'b1;
      cur_hr   = 5'd0;
      cur_min  = 6'd0;

      // Reset with all buttons active.
      wait_cyc(3);
      check_val("rst_set_hr", set_hr, 0);
      check_val("rst_set_min", set_min, 0);
      check_val("rst_load", load, 0);
      check_val("rst_active", set_active, 0);
      check_val("rst_field", edit_field, 0);
      check_val("rst_blink", blink, 0);
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      reset_n  = 1'b1;
      wait_cyc(20);
      check_val("rst_no_load", load_seen, 0);
      check_val("rst_still_run", set_active, 0);

      // Enter edit from 22:58.
      cur_hr  = 5'd22;
      cur_min = 6'd58;
      press(1'b1, 1'b0, 1'b0);
      check_val("enter_hr", set_hr, 22);
      check_val("enter_min", set_min, 58);
      check_val("enter_field", edit_field, 1);
      check_val("enter_active", set_active, 1);

      // Bouncing up button: 2-cycle toggles, then a stable hold.
      for (int i = 0; i < 10; i++) begin
         btn_up = (i % 2 == 0);
         wait_cyc(2);
      end
      check_val("bounce_none", set_hr, 22);
      btn_up = 1'b1;
      wait_cyc(7);
      check_val("bounce_early", set_hr, 22);
      wait_cyc(1);
      check_val("bounce_step", set_hr, 23);
      wait_cyc(10);
      check_val("bounce_single", set_hr, 23);
      btn_up = 1'b0;
      wait_cyc(8);

      // Hour wrap in both directions.
      press(1'b0, 1'b1, 1'b0);
      check_val("hr_wrap_up", set_hr, 0);
      press(1'b0, 1'b0, 1'b1);
      check_val("hr_wrap_down", set_hr, 23);
      press(1'b0, 1'b1, 1'b0);
      check_val("hr_back_0", set_hr, 0);

      // mode + up together: mode wins.
      press(1'b1, 1'b1, 1'b0);
      check_val("mode_wins_field", edit_field, 2);
      check_val("mode_wins_hr", set_hr, 0);
      check_val("mode_wins_min", set_min, 58);

      // Minute wrap in both directions.
      press(1'b0, 1'b1, 1'b0);
      check_val("min_59", set_min, 59);
      press(1'b0, 1'b1, 1'b0);
      check_val("min_wrap_up", set_min, 0);
      press(1'b0, 1'b0, 1'b1);
      check_val("min_wrap_down", set_min, 59);
      press(1'b0, 1'b1, 1'b0);
      check_val("min_back_0", set_min, 0);

      // up + down together: nothing changes.
      press(1'b0, 1'b1, 1'b1);
      check_val("updown_min", set_min, 0);
      check_val("updown_field", edit_field, 2);

      // Commit: load high only on the cycle after the FSM reacts.
      btn_mode = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         wait_cyc(1);
         check_val($sformatf("load_c%0d", i), load, (i == 8));
         if (i == 8) begin
            check_val("load_hr", set_hr, 0);
            check_val("load_min", set_min, 0);
         end
      end
      btn_mode = 1'b0;
      wait_cyc(8);
      check_val("post_active", set_active, 0);
      check_val("post_field", edit_field, 0);
      check_val("post_hr_hold", set_hr, 0);
      check_val("post_load_count", load_seen, 1);

      // Reset in the middle of SET_MIN abandons the edit.
      cur_hr  = 5'd5;
      cur_min = 6'd30;
      press(1'b1, 1'b0, 1'b0);
      check_val("mid_enter_hr", set_hr, 5);
      press(1'b1, 1'b0, 1'b0);
      check_val("mid_field", edit_field, 2);
      reset_n = 1'b0;
      wait_cyc(2);
      reset_n = 1'b1;
      check_val("mid_rst_hr", set_hr, 0);
      check_val("mid_rst_min", set_min, 0);
      check_val("mid_rst_active", set_active, 0);
      check_val("mid_rst_field", edit_field, 0);
      wait_cyc(20);
      check_val("mid_rst_no_load", load_seen, 1);

      // Blink restarts on entry and toggles every 250 cycles.
      btn_mode = 1'b1;
      wait_cyc(8);
      btn_mode = 1'b0;
      check_val("blink_entry_field", edit_field, 1);
      check_val("blink_entry", blink, 0);
      wait_cyc(249);
      check_val("blink_pre1", blink, 0);
      wait_cyc(1);
      check_val("blink_rise", blink, 1);
      wait_cyc(249);
      check_val("blink_pre2", blink, 1);
      wait_cyc(1);
      check_val("blink_fall", blink, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
